// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for the 16-bit CPU: instruction-class decode, multiply wait,
// stack-depth tracking with faults, illegal-opcode trap and vectored interrupt entry.
module control_sequencer #(
    parameter int unsigned IW          = 16,
    parameter int unsigned STACK_DEPTH = 16,
    parameter int unsigned MUL_CYCLES  = 2,
    localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [IW-1:0] instruction,
    input  logic          instr_valid,
    input  logic          irq,
    input  logic          irq_en,
    output logic [2:0]    state,
    output logic [3:0]    op_class,
    output logic          ir_en,
    output logic          pc_cnt_en,
    output logic          pc_sload,
    output logic [1:0]    jump_sel,
    output logic [1:0]    ram_data_addr_sel,
    output logic          ram_wren_data,
    output logic          stack_push,
    output logic          stack_pop,
    output logic          regf_write_en,
    output logic          alu_start,
    output logic          irq_ack,
    output logic          stop,
    output logic [2:0]    fault,
    output logic [DW-1:0] sp_depth
);

    localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'b000,
        S_EXEC1 = 3'b010,
        S_EXEC2 = 3'b001,
        S_MULW  = 3'b011,
        S_INT1  = 3'b100,
        S_INT2  = 3'b101,
        S_HALT  = 3'b111
    } state_e;

    localparam logic [2:0] F_NONE      = 3'd0;
    localparam logic [2:0] F_STP       = 3'd1;
    localparam logic [2:0] F_OVERFLOW  = 3'd2;
    localparam logic [2:0] F_UNDERFLOW = 3'd3;
    localparam logic [2:0] F_ILLEGAL   = 3'd4;

    state_e        state_q, state_d;
    logic [3:0]    op_class_q, op_class_d;
    logic [1:0]    mem_sub_q, mem_sub_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic [2:0]    fault_q, fault_d;
    logic [DW-1:0] sp_depth_q, sp_depth_d;

    logic [3:0] opcode;
    logic [3:0] sub;
    logic       boundary, do_push, do_pop, go_halt;
    logic [2:0] halt_code;

    logic       ir_en_c, pc_cnt_en_c, pc_sload_c, ram_wren_data_c;
    logic       stack_push_c, stack_pop_c, regf_write_en_c, alu_start_c, irq_ack_c;
    logic [1:0] jump_sel_c, addr_sel_c;

    assign opcode = instruction[IW-1 -: 4];
    assign sub    = instruction[IW-5 -: 4];

    if (IW > 8) begin : g_low_unused
        logic unused_low;
        assign unused_low = ^instruction[IW-9:0];
    end

    // Next-state, datapath strobes and stack bookkeeping
    always_comb begin
        state_d         = state_q;
        op_class_d      = op_class_q;
        mem_sub_d       = mem_sub_q;
        mul_cnt_d       = mul_cnt_q;
        fault_d         = fault_q;
        sp_depth_d      = sp_depth_q;
        ir_en_c         = 1'b0;
        pc_cnt_en_c     = 1'b0;
        pc_sload_c      = 1'b0;
        ram_wren_data_c = 1'b0;
        stack_push_c    = 1'b0;
        stack_pop_c     = 1'b0;
        regf_write_en_c = 1'b0;
        alu_start_c     = 1'b0;
        irq_ack_c       = 1'b0;
        jump_sel_c      = 2'b00;
        addr_sel_c      = 2'b00;
        boundary        = 1'b0;
        do_push         = 1'b0;
        do_pop          = 1'b0;
        go_halt         = 1'b0;
        halt_code       = F_NONE;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_en_c     = 1'b1;
                    pc_cnt_en_c = 1'b1;
                    state_d     = S_EXEC1;
                end
            end
            S_EXEC1: begin
                op_class_d = opcode;
                mem_sub_d  = sub[3:2];
                mul_cnt_d  = '0;
                case (opcode)
                    4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101: begin
                        regf_write_en_c = 1'b1;
                        boundary        = 1'b1;
                    end
                    4'b0110: begin
                        state_d = S_EXEC2;
                        case (sub[3:2])
                            2'b00:   do_push = 1'b1;
                            2'b01:   addr_sel_c = 2'b00;
                            2'b10:   do_pop = 1'b1;
                            default: ram_wren_data_c = 1'b1;
                        endcase
                    end
                    4'b1000, 4'b1001: begin
                        alu_start_c = 1'b1;
                        state_d     = S_MULW;
                    end
                    4'b1100: begin
                        pc_sload_c = 1'b1;
                        boundary   = 1'b1;
                    end
                    4'b1101: begin
                        do_push = 1'b1;
                        state_d = S_EXEC2;
                    end
                    4'b1110: begin
                        pc_cnt_en_c = 1'b1;
                        addr_sel_c  = 2'b10;
                        state_d     = S_EXEC2;
                    end
                    4'b1111: begin
                        if (sub == 4'b0000) begin
                            do_pop  = 1'b1;
                            state_d = S_EXEC2;
                        end else begin
                            go_halt   = 1'b1;
                            halt_code = (sub == 4'b0001) ? F_STP : F_ILLEGAL;
                        end
                    end
                    default: begin
                        go_halt   = 1'b1;
                        halt_code = F_ILLEGAL;
                    end
                endcase
            end
            S_EXEC2: begin
                boundary = 1'b1;
                case (op_class_q)
                    4'b0110: regf_write_en_c = (mem_sub_q == 2'b01) || (mem_sub_q == 2'b10);
                    4'b1101: pc_sload_c = 1'b1;
                    4'b1110: regf_write_en_c = 1'b1;
                    4'b1111: begin
                        pc_sload_c = 1'b1;
                        jump_sel_c = 2'b01;
                    end
                    default: ;
                endcase
            end
            S_MULW: begin
                if (mul_cnt_q == CW'(MUL_CYCLES - 1)) begin
                    regf_write_en_c = 1'b1;
                    boundary        = 1'b1;
                end else begin
                    mul_cnt_d = mul_cnt_q + CW'(1);
                end
            end
            S_INT1: begin
                do_push = 1'b1;
                state_d = S_INT2;
            end
            S_INT2: begin
                pc_sload_c = 1'b1;
                jump_sel_c = 2'b10;
                irq_ack_c  = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase

        // Full/empty checks suppress the stack strobes and trap instead
        if (do_push) begin
            addr_sel_c = 2'b01;
            if (sp_depth_q == DW'(STACK_DEPTH)) begin
                go_halt   = 1'b1;
                halt_code = F_OVERFLOW;
            end else begin
                ram_wren_data_c = 1'b1;
                stack_push_c    = 1'b1;
            end
        end
        if (do_pop) begin
            addr_sel_c = 2'b01;
            if (sp_depth_q == '0) begin
                go_halt   = 1'b1;
                halt_code = F_UNDERFLOW;
            end else begin
                stack_pop_c = 1'b1;
            end
        end

        if (boundary) begin
            state_d = (irq && irq_en) ? S_INT1 : S_FETCH;
        end
        if (go_halt) begin
            state_d = S_HALT;
            fault_d = halt_code;
        end

        sp_depth_d = sp_depth_q + DW'(stack_push_c) - DW'(stack_pop_c);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            op_class_q <= '0;
            mem_sub_q  <= '0;
            mul_cnt_q  <= '0;
            fault_q    <= F_NONE;
            sp_depth_q <= '0;
        end else begin
            state_q    <= state_d;
            op_class_q <= op_class_d;
            mem_sub_q  <= mem_sub_d;
            mul_cnt_q  <= mul_cnt_d;
            fault_q    <= fault_d;
            sp_depth_q <= sp_depth_d;
        end
    end

    // Strobes are held quiet for the whole cycle in which reset is asserted
    assign state             = state_q;
    assign op_class          = op_class_q;
    assign fault             = fault_q;
    assign sp_depth          = sp_depth_q;
    assign stop              = reset_n && (state_q == S_HALT);
    assign ir_en             = reset_n && ir_en_c;
    assign pc_cnt_en         = reset_n && pc_cnt_en_c;
    assign pc_sload          = reset_n && pc_sload_c;
    assign ram_wren_data     = reset_n && ram_wren_data_c;
    assign stack_push        = reset_n && stack_push_c;
    assign stack_pop         = reset_n && stack_pop_c;
    assign regf_write_en     = reset_n && regf_write_en_c;
    assign alu_start         = reset_n && alu_start_c;
    assign irq_ack           = reset_n && irq_ack_c;
    assign jump_sel          = reset_n ? jump_sel_c : 2'b00;
    assign ram_data_addr_sel = reset_n ? addr_sel_c : 2'b00;

endmodule
